// File: rtl/msrv32_pc_unit.sv
// Program-counter stage: next-PC selection, architectural PC register and fetch address.
// Optional retire counter on instret_out is enabled by defining MSRV32_PC_INSTRET_EN.
module msrv32_pc_unit #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
    parameter int          INSTRET_W    = 64
) (
    input  logic                 ms_riscv32_mp_clk_in,
    input  logic                 ms_riscv32_mp_rst_in,
    input  logic [1:0]           pc_src_in,
    input  logic                 branch_taken_in,
    input  logic [31:0]          iadder_in,
    input  logic [31:0]          epc_in,
    input  logic [31:0]          trap_address_in,
    input  logic                 ahb_ready_in,
    output logic [31:0]          pc_out,
    output logic [31:0]          pc_plus_4_out,
    output logic [31:0]          pc_mux_out,
    output logic [31:0]          i_addr_out,
    output logic                 misaligned_instr_out,
    output logic                 flush_out,
    output logic [INSTRET_W-1:0] instret_out
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_BOOT  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        flush_q;

    logic [31:0] pc_plus_4;
    logic [31:0] next_pc;
    logic [31:0] pc_mux;
    logic        misaligned;
    logic        redirect;
    logic        accept;

    assign pc_plus_4  = pc_q + 32'd4;
    // Jump targets have bit 0 forced low, as for JALR.
    assign next_pc    = branch_taken_in ? (iadder_in & ~32'h1) : pc_plus_4;
    assign misaligned = (pc_src_in == 2'b11) & branch_taken_in & iadder_in[1];
    assign redirect   = (pc_src_in != 2'b11) | branch_taken_in;
    assign accept     = ahb_ready_in & ~misaligned;

    always_comb begin
        pc_mux = next_pc;
        case (pc_src_in)
            2'b00:   pc_mux = BOOT_ADDRESS;
            2'b01:   pc_mux = epc_in;
            2'b10:   pc_mux = trap_address_in;
            default: pc_mux = next_pc;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q <= S_RESET;
            pc_q    <= BOOT_ADDRESS;
            flush_q <= 1'b1;
        end else begin
            case (state_q)
                S_RESET: state_q <= S_BOOT;
                S_BOOT: begin
                    if (ahb_ready_in) begin
                        state_q <= S_RUN;
                        flush_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    // A misaligned target wins over a stall so the trap is never delayed.
                    if (misaligned) begin
                        flush_q <= 1'b1;
                    end else if (accept) begin
                        pc_q    <= pc_mux;
                        flush_q <= redirect;
                    end
                end
                default: state_q <= S_RESET;
            endcase
        end
    end

`ifdef MSRV32_PC_INSTRET_EN
    logic [INSTRET_W-1:0] instret_q;

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            instret_q <= '0;
        end else if ((state_q == S_RUN) && accept) begin
            instret_q <= instret_q + 1'b1;
        end
    end

    assign instret_out = instret_q;
`else
    assign instret_out = '0;
`endif

    assign pc_out               = pc_q;
    assign pc_plus_4_out        = pc_plus_4;
    assign pc_mux_out           = pc_mux;
    assign misaligned_instr_out = misaligned;
    assign flush_out            = flush_q;
    assign i_addr_out           = (state_q == S_RUN) ? pc_mux : BOOT_ADDRESS;

endmodule
